elem_packer: RTL
================

// Module: elem_packer
// PURPOSE
// Write-side counterpart of the EAU lane-expansion mux. Takes VLEN-bit beats holding up to BS
// variable-length elements (element k = ilen[k] bytes starting at byte lane ipos[k]).
// Compacts those elements back-to-back into a contiguous byte stream.
// Emits full VLEN-bit beats on a valid/ready output; a final partial beat is emitted on i_last.
// PARAMETERS
// VLEN  256  vector width in bits
// BSW   5    log2 of byte lanes; BS=1<<BSW lanes, WW=8-BSW+1 length-field width
// PORTS
// clk       in   1            clock
// rst_n     in   1            synchronous active-low reset
// i_valid   in   1            input beat valid
// i_ready   out  1            input beat accepted when i_valid&&i_ready
// i_data    in   VLEN         source bytes; lane b = bits [8b+7:8b]
// i_inum    in   BSW+1        number of valid elements, 0..BS
// i_ilen    in   WW x BS      element byte length, 0 allowed
// i_ipos    in   BSW x BS     element start lane
// i_last    in   1            final beat of stream; forces drain
// o_valid   out  1            output beat valid
// o_ready   in   1            output beat consumed when o_valid&&o_ready
// o_data    out  VLEN         packed bytes, lane 0 first; lanes >= o_nbytes are zero
// o_nbytes  out  BSW+1        valid bytes in o_data, 0..BS
// o_last    out  1            final beat of stream
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): o_valid=0, o_data=0, o_nbytes=0, o_last=0; residual cnt=0; state RUN.
//   Reset mid-stream discards the residual. i_ready=0 while rst_n=0.
// - States: RUN, FLUSH. i_ready = rst_n && state==RUN && (!o_valid || o_ready).
// - Packing per accepted beat:
//   - n = sum of ilen[k] for k < i_inum.
//   - Element k occupies packed offset prev[k] = sum of ilen[j] for j<k.
//   - Its bytes are appended after the residual: total = cnt + n.
// - Per-beat legality: n <= BS and ipos[k]+ilen[k] <= BS for all k < i_inum.
// - Register update on accept, latency 1 cycle (accept edge -> o_valid=1):
//   - total >= BS: o_data = first BS bytes, o_nbytes=BS, residual = remaining total-BS bytes.
//     o_last = i_last && total==BS.
//     If i_last && total>BS, go FLUSH.
//   - total < BS && i_last: o_data = total bytes, zero-padded, o_nbytes=total, o_last=1, cnt=0.
//     total==0 still produces one beat with o_nbytes=0.
//   - total < BS && !i_last: no output; cnt=total.
// - FLUSH: when !o_valid || o_ready, load the residual as a partial beat (o_nbytes=cnt, o_last=1),
//   set cnt=0, return to RUN.
// - Output hold: o_data/o_nbytes/o_last stable while o_valid && !o_ready.
//   o_valid drops after consumption unless a new beat loads on the same edge.
// - Width: cnt < BS between beats; total <= 2*BS-1 in BSW+2 bits; byte offsets are mod 2*BS in the
//   residual shift register.
// CONFIGURATION
// - ELEM_PACKER_ERR_EN defined: adds output err (1 bit, reset 0).
//   - err is set sticky, cleared only by reset, on any accepted beat violating the per-beat legality rules.
//   - The offending beat is still packed using lengths truncated to the legal lane range.
// - ELEM_PACKER_ERR_EN not defined: no err port; illegal beats produce undefined o_data but never
//   corrupt the handshake or state.
// STRUCTURE
// - Shared package eau_pkg: BS/BLEN/WW derivations, typedefs lane_t (8b), len_t (WW), pos_t (BSW),
//   cnt_t (BSW+1), elem_packer_state_e {RUN, FLUSH}.
// - Sub-module pack_sel (combinational): prefix-sums i_ilen.
//   - For each packed lane i it outputs the source lane ipos[k]+i-prev[k] of the covering element,
//     plus a lane-valid bit.
//   - Top level does the residual concat, beat split and FSM.
// TESTING
// 1. Four elements, len 8, ipos 0/8/16/24, i_last=0 -> next cycle o_valid, o_data==i_data,
//    o_nbytes=32, o_last=0, cnt=0.
// 2. Two beats of 5 elems x len 5 (25 B each), then inum=0 beat with i_last:
//    - after beat 2: 32-byte beat out, o_last=0;
//    - after beat 3: o_nbytes=18, o_last=1, bytes in order.
// 3. o_ready held low 3 cycles with o_valid=1 -> i_ready=0, o_data/o_nbytes stable.
//    Raise o_ready -> next beat accepted that cycle.
// 4. Residual 10 B + beat of 30 B with i_last:
//    - full beat o_last=0;
//    - then FLUSH emits o_nbytes=8, o_last=1, zero lanes 8..31;
//    - i_ready=0 during FLUSH.
// 5. ELEM_PACKER_ERR_EN: beat with ilen sum 36 -> err=1 next cycle and stays 1 until rst_n=0.
//    ipos=30, ilen=4 also sets err.
// 6. Reset asserted with residual 10 B, then inum=0 beat with i_last -> single beat o_nbytes=0,
//    o_last=1.

Source files
------------

// File: rtl/eau_pkg.sv
// Shared EAU definitions: lane geometry, element field types and the packer FSM states.
package eau_pkg;
  localparam int EAU_VLEN = 256;
  localparam int EAU_BSW  = 5;
  localparam int EAU_BS   = 1 << EAU_BSW;
  localparam int EAU_BLEN = 8 * EAU_BS;
  localparam int EAU_WW   = 8 - EAU_BSW + 1;

  typedef logic [7:0]         lane_t;
  typedef logic [EAU_WW-1:0]  len_t;
  typedef logic [EAU_BSW-1:0] pos_t;
  typedef logic [EAU_BSW:0]   cnt_t;

  typedef enum logic {RUN, FLUSH} elem_packer_state_e;
endpackage

// File: rtl/pack_sel.sv
// Combinational lane selector: prefix-sums element lengths and, for every packed lane,
// returns the source byte lane of the element covering it. Lengths are clipped to the lane range.
module pack_sel #(
  parameter int  BSW = 5,
  parameter int  WW  = 4,
  localparam int BS  = 1 << BSW,
  localparam int PW  = BSW + WW + 1
) (
  input  logic [BSW:0]             inum,
  input  logic [BS-1:0][WW-1:0]    ilen,
  input  logic [BS-1:0][BSW-1:0]   ipos,
  output logic [BS-1:0][BSW-1:0]   src,
  output logic [BS-1:0]            lvld,
  output logic [BSW:0]             n,
  output logic                     bad
);
  logic [BS-1:0][PW-1:0] prev, elen;
  logic [PW-1:0]         acc, raw, room;

  always_comb begin
    acc  = '0;
    raw  = '0;
    room = '0;
    bad  = 1'b0;
    prev = '0;
    elen = '0;
    for (int k = 0; k < BS; k++) begin
      room    = PW'(BS) - PW'(ipos[k]);
      prev[k] = acc;
      if ((BSW+1)'(k) < inum) begin
        raw = raw + PW'(ilen[k]);
        if (PW'(ilen[k]) > room) begin
          bad     = 1'b1;
          elen[k] = room;
        end else begin
          elen[k] = PW'(ilen[k]);
        end
      end
      acc = acc + elen[k];
    end
    if (raw > PW'(BS)) bad = 1'b1;
    // Packed lanes past BS are dropped, which keeps the residual count bounded.
    n = (acc > PW'(BS)) ? (BSW+1)'(BS) : (BSW+1)'(acc);
  end

  for (genvar i = 0; i < BS; i++) begin : g_lane
    logic [BSW-1:0] s;
    logic           h;
    always_comb begin
      s = '0;
      h = 1'b0;
      for (int k = 0; k < BS; k++) begin
        if (PW'(i) >= prev[k] && PW'(i) < prev[k] + elen[k]) begin
          h = 1'b1;
          s = BSW'(PW'(ipos[k]) + PW'(i) - prev[k]);
        end
      end
    end
    assign src[i]  = s;
    assign lvld[i] = h;
  end
endmodule

// File: rtl/elem_packer.sv
// Element packer: compacts variable-length elements into full VLEN-bit beats with a residual.
// Optional ELEM_PACKER_ERR_EN adds a sticky err output for illegal beats.
module elem_packer
  import eau_pkg::*;
#(
  parameter int  VLEN = EAU_VLEN,
  parameter int  BSW  = EAU_BSW,
  localparam int BS   = 1 << BSW,
  localparam int WW   = 8 - BSW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [VLEN-1:0]         i_data,
  input  logic [BSW:0]            i_inum,
  input  logic [BS-1:0][WW-1:0]   i_ilen,
  input  logic [BS-1:0][BSW-1:0]  i_ipos,
  input  logic                    i_last,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [VLEN-1:0]         o_data,
  output logic [BSW:0]            o_nbytes,
  output logic                    o_last
`ifdef ELEM_PACKER_ERR_EN
  ,output logic                   err
`endif
);
  logic [BS-1:0][BSW-1:0] src;
  logic [BS-1:0]          lvld;
  logic [BSW:0]           n;
  logic                   bad;

  pack_sel #(.BSW(BSW), .WW(WW)) u_sel (
    .inum (i_inum),
    .ilen (i_ilen),
    .ipos (i_ipos),
    .src  (src),
    .lvld (lvld),
    .n    (n),
    .bad  (bad)
  );

  lane_t [BS-1:0] din, gat, res_q;
  assign din = i_data;
  for (genvar i = 0; i < BS; i++) begin : g_gat
    assign gat[i] = lvld[i] ? din[src[i]] : 8'h00;
  end

  logic [BSW:0]      cnt_q;
  logic [BSW+1:0]    total;
  logic [2*VLEN-1:0] cat;
  logic              acc, full, fl;
  elem_packer_state_e state_q, state_d;

  // Residual bytes sit below cnt_q; the new bytes are shifted in right behind them.
  assign total = {1'b0, cnt_q} + {1'b0, n};
  assign cat   = {{VLEN{1'b0}}, res_q} | ({{VLEN{1'b0}}, gat} << {cnt_q, 3'b000});
  assign full  = total >= (BSW+2)'(BS);

  assign i_ready = rst_n && state_q == RUN && (!o_valid || o_ready);
  assign acc     = i_valid && i_ready;
  assign fl      = state_q == FLUSH && (!o_valid || o_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (acc && i_last && total > (BSW+2)'(BS)) state_d = FLUSH;
      FLUSH:   if (fl) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_nbytes <= '0;
      o_last   <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else if (fl) begin
      o_valid  <= 1'b1;
      o_data   <= res_q;
      o_nbytes <= cnt_q;
      o_last   <= 1'b1;
      cnt_q    <= '0;
      res_q    <= '0;
    end else if (acc) begin
      if (full) begin
        o_valid  <= 1'b1;
        o_data   <= cat[VLEN-1:0];
        o_nbytes <= (BSW+1)'(BS);
        o_last   <= i_last && total == (BSW+2)'(BS);
        cnt_q    <= (BSW+1)'(total - (BSW+2)'(BS));
        res_q    <= cat[2*VLEN-1:VLEN];
      end else if (i_last) begin
        o_valid  <= 1'b1;
        o_data   <= cat[VLEN-1:0];
        o_nbytes <= (BSW+1)'(total);
        o_last   <= 1'b1;
        cnt_q    <= '0;
        res_q    <= '0;
      end else begin
        o_valid  <= 1'b0;
        cnt_q    <= (BSW+1)'(total);
        res_q    <= cat[VLEN-1:0];
      end
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef ELEM_PACKER_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)         err <= 1'b0;
    else if (acc && bad) err <= 1'b1;
  end
`else
  logic unused_bad;
  assign unused_bad = bad;
`endif
endmodule
